fetch_pc_unit: RTL and testbench

- Program-counter and instruction-fetch stage sitting directly upstream of the branch unit.
- Holds the PC and issues word fetches to instruction memory over a req/gnt + rvalid handshake.
- Presents one instruction at a time to decode via valid/ready.
- Drives pc_current, the PC of the instruction in decode, and consumes branch_taken/branch_target as branch_en/branch_addr to redirect fetch.

---
 rtl/fetch_pc_unit_pkg.sv | 24 ++
 rtl/fetch_pc_unit_next_pc.sv | 22 ++
 rtl/fetch_pc_unit.sv | 128 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch PC unit: FSM states, next-PC select codes
// and a saturating counter helper used when FETCH_PERF_CNT_EN is set.
package fetch_pc_unit_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NPC_HOLD   = 2'd0,
        NPC_STEP   = 2'd1,
        NPC_BRANCH = 2'd2
    } npc_sel_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc.sv
// Next fetch-PC select: hold, sequential step or branch redirect.
module fetch_pc_unit_next_pc
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_STEP = 16'd1
) (
    input  npc_sel_e        sel_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] branch_addr_i,
    output logic [PC_W-1:0] pc_o
);

    always_comb begin
        pc_o = pc_i;
        unique case (sel_i)
            NPC_STEP:   pc_o = pc_i + PC_STEP;
            NPC_BRANCH: pc_o = branch_addr_i;
            default:    pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC / instruction-fetch stage: req/gnt+rvalid fetch, valid/ready to decode.
// Optional saturating perf counters behind FETCH_PERF_CNT_EN.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd1,
    parameter int              INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_addr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_current
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);

    state_e               state_q;
    logic [PC_W-1:0]      fetch_pc_q;
    logic [PC_W-1:0]      fetch_pc_d;
    logic [PC_W-1:0]      pc_cur_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 drop_q;
    npc_sel_e             npc_sel;

    logic st_legal;
    assign st_legal = (state_q == S_REQ) || (state_q == S_RESP)
                   || (state_q == S_OUT);

    always_comb begin
        npc_sel = NPC_HOLD;
        if (st_legal && branch_en)
            npc_sel = NPC_BRANCH;
        else if (state_q == S_OUT && instr_ready)
            npc_sel = NPC_STEP;
    end

    fetch_pc_unit_next_pc #(
        .PC_STEP(PC_STEP)
    ) u_next_pc (
        .sel_i        (npc_sel),
        .pc_i         (fetch_pc_q),
        .branch_addr_i(branch_addr),
        .pc_o         (fetch_pc_d)
    );

    logic leave_out;
    logic discard;
    assign leave_out = (state_q == S_OUT) && (branch_en || instr_ready);
    assign discard   = (state_q == S_RESP) && imem_rvalid
                    && (drop_q || branch_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            pc_cur_q   <= RESET_PC;
            instr_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt) begin
                        state_q <= S_RESP;
                        drop_q  <= branch_en;
                    end
                end
                S_RESP: begin
                    if (imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (discard) begin
                            state_q <= S_REQ;
                        end else begin
                            instr_q  <= imem_rdata;
                            pc_cur_q <= fetch_pc_q;
                            state_q  <= S_OUT;
                        end
                    end else if (branch_en) begin
                        drop_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (leave_out) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_q;
    logic [15:0] flushed_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (leave_out) fetched_q <= sat_inc(fetched_q);
            if (discard)   flushed_q <= sat_inc(flushed_q);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

    // Request and valid are masked during the reset cycle itself.
    assign imem_req    = rst_n && (state_q == S_REQ);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = rst_n && (state_q == S_OUT);
    assign instr_out   = instr_q;
    assign pc_current  = pc_cur_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: two instances (RESET_PC 0 and
// FFFF) share stimulus; a transaction model checks every cycle.
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, br_en, gnt, ready;
    logic        auto_rv, extra_rv, ovr_en;
    logic [15:0] br_addr, ovr_data;

    logic        a_req, a_valid, a_rvalid;
    logic [15:0] a_addr, a_instr, a_pc, a_rdata;
    logic        a_pend = 1'b0;
    logic [15:0] a_paddr = '0;

    logic        b_req, b_valid, b_rvalid;
    logic [15:0] b_addr, b_instr, b_pc, b_rdata;
    logic        b_pend = 1'b0;
    logic [15:0] b_paddr = '0;

    logic [15:0] a_pf, a_pfl, b_pf, b_pfl;

    assign a_rvalid = (a_pend & auto_rv) | extra_rv;
    assign a_rdata  = ovr_en ? ovr_data : 16'hA000 + a_paddr;
    assign b_rvalid = (b_pend & auto_rv) | extra_rv;
    assign b_rdata  = ovr_en ? ovr_data : 16'hA000 + b_paddr;

    fetch_pc_unit u_a (
        .clk(clk), .rst_n(rst_n),
        .branch_en(br_en), .branch_addr(br_addr),
        .imem_req(a_req), .imem_addr(a_addr),
        .imem_gnt(gnt), .imem_rvalid(a_rvalid),
        .imem_rdata(a_rdata),
        .instr_valid(a_valid), .instr_ready(ready),
        .instr_out(a_instr), .pc_current(a_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(a_pf), .perf_flushed(a_pfl)
`endif
    );

    fetch_pc_unit #(.RESET_PC(16'hFFFF)) u_b (
        .clk(clk), .rst_n(rst_n),
        .branch_en(br_en), .branch_addr(br_addr),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_gnt(gnt), .imem_rvalid(b_rvalid),
        .imem_rdata(b_rdata),
        .instr_valid(b_valid), .instr_ready(ready),
        .instr_out(b_instr), .pc_current(b_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(b_pf), .perf_flushed(b_pfl)
`endif
    );

`ifndef FETCH_PERF_CNT_EN
    assign a_pf = '0;
    assign a_pfl = '0;
    assign b_pf = '0;
    assign b_pfl = '0;
`endif

    logic [15:0] grants_a[$];
    logic [15:0] grants_b[$];
    logic [15:0] acc_i[$];
    logic [15:0] acc_p[$];
    bit          dead_seen = 1'b0;

    // Memory responder: one-cycle response to each granted request.
    always @(posedge clk) begin
        a_pend  <= a_req && gnt;
        a_paddr <= a_addr;
        b_pend  <= b_req && gnt;
        b_paddr <= b_addr;
        if (a_req === 1'b1 && gnt) grants_a.push_back(a_addr);
        if (b_req === 1'b1 && gnt) grants_b.push_back(b_addr);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] hd;
        logic [15:0] hp;
        logic [15:0] fet;
        logic [15:0] fl;
        bit          out;
        bit          taint;
        bit          hold;
        bit          armed;
    } m_t;

    m_t ma = '{default: '0};
    m_t mb = '{default: '0};

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_cycle(
        input  string       nm,
        input  logic [15:0] rpc,
        input  m_t          mi,
        input  logic        req,
        input  logic [15:0] addr,
        input  logic        valid,
        input  logic [15:0] instr,
        input  logic [15:0] pc,
        input  logic        rv,
        input  logic [15:0] rd,
        input  logic [15:0] pf,
        input  logic [15:0] pfl,
        output m_t          mo
    );
        bit want_req;
        mo = mi;
        want_req = !mi.out && !mi.hold && rst_n;
        if (mi.armed) begin
            chk({nm, ".imem_req"}, req, want_req);
            if (want_req) chk({nm, ".imem_addr"}, addr, mi.pc);
            chk({nm, ".instr_valid"}, valid, mi.hold && rst_n);
            if (mi.hold && rst_n) begin
                chk({nm, ".instr_out"}, instr, mi.hd);
                chk({nm, ".pc_current"}, pc, mi.hp);
            end
`ifdef FETCH_PERF_CNT_EN
            chk({nm, ".perf_fetched"}, pf, mi.fet);
            chk({nm, ".perf_flushed"}, pfl, mi.fl);
`endif
        end
        if (!rst_n) begin
            mo = '{default: '0};
            mo.pc = rpc;
            mo.armed = 1'b1;
        end else if (mi.armed) begin
            if (mi.hold) begin
                if (br_en || ready) begin
                    mo.hold = 1'b0;
                    mo.fet = sat(mi.fet);
                    mo.pc = br_en ? br_addr : mi.pc + 16'd1;
                end
            end else if (mi.out) begin
                if (rv) begin
                    mo.out = 1'b0;
                    if (mi.taint || br_en) begin
                        mo.fl = sat(mi.fl);
                        mo.taint = 1'b0;
                    end else begin
                        mo.hold = 1'b1;
                        mo.hd = rd;
                        mo.hp = mi.pc;
                    end
                end else if (br_en) begin
                    mo.taint = 1'b1;
                end
                if (br_en) mo.pc = br_addr;
            end else begin
                if (gnt) begin
                    mo.out = 1'b1;
                    mo.taint = br_en;
                end
                if (br_en) mo.pc = br_addr;
            end
        end
    endtask

    always @(negedge clk) begin
        m_t na;
        m_t nb;
        if (a_valid === 1'b1 && rst_n && ready && !br_en) begin
            acc_i.push_back(a_instr);
            acc_p.push_back(a_pc);
        end
        if (a_valid === 1'b1 && a_instr == 16'hDEAD) dead_seen = 1'b1;
        model_cycle("A", 16'h0000, ma, a_req, a_addr, a_valid,
                    a_instr, a_pc, a_rvalid, a_rdata, a_pf, a_pfl, na);
        model_cycle("B", 16'hFFFF, mb, b_req, b_addr, b_valid,
                    b_instr, b_pc, b_rvalid, b_rdata, b_pf, b_pfl, nb);
        ma = na;
        mb = nb;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (a_valid !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        if (k >= 40) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual=no_valid required=valid", nm);
        end
    endtask

    int gsz;
    bit saw5;

    initial begin
        rst_n = 1'b0; br_en = 1'b0; br_addr = '0;
        gnt = 1'b1; ready = 1'b1; auto_rv = 1'b1;
        extra_rv = 1'b0; ovr_en = 1'b0; ovr_data = '0;
        cyc(2);
        chk("rst_instr_out", a_instr, 16'h0000);
        chk("rst_pc_a", a_pc, 16'h0000);
        chk("rst_pc_b", b_pc, 16'hFFFF);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_req", a_req, 1'b0);
        rst_n = 1'b1;

        // Sequential stream, ready always high.
        begin
            int k = 0;
            while (acc_i.size() < 3 && k < 40) begin
                cyc(1);
                k++;
            end
        end
        ready = 1'b0;
        chk("seq_count", acc_i.size(), 3);
        if (acc_i.size() >= 3) begin
            chk("seq_i0", acc_i[0], 16'hA000);
            chk("seq_i1", acc_i[1], 16'hA001);
            chk("seq_i2", acc_i[2], 16'hA002);
            chk("seq_p0", acc_p[0], 16'h0000);
            chk("seq_p2", acc_p[2], 16'h0002);
        end

        // Stall in S_OUT for 5 cycles.
        wait_valid("stall");
        cyc(5);
        chk("stall_valid", a_valid, 1'b1);
        chk("stall_instr", a_instr, 16'hA003);
        chk("stall_pc", a_pc, 16'h0003);
        chk("stall_req", a_req, 1'b0);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;

        // Branch in S_OUT at pc 4 with ready also high.
        wait_valid("pc4");
        chk("pc4_pc", a_pc, 16'h0004);
        br_en = 1'b1; br_addr = 16'h0040; ready = 1'b1;
        cyc(1);
        br_en = 1'b0;
        gsz = grants_a.size();
        wait_valid("br40");
        chk("br40_addr", grants_a.size() > gsz ? grants_a[gsz] : 16'hxxxx,
            16'h0040);
        chk("br40_pc", a_pc, 16'h0040);
        saw5 = 1'b0;
        foreach (grants_a[i]) if (grants_a[i] == 16'h0005) saw5 = 1'b1;
        chk("no_fetch_5", saw5, 1'b0);

        // Branch while waiting for a response; response is DEAD.
        gnt = 1'b0;
        cyc(1);
        gnt = 1'b1; auto_rv = 1'b0;
        cyc(1);
        gnt = 1'b0; br_en = 1'b1; br_addr = 16'h0100;
        cyc(1);
        br_en = 1'b0; extra_rv = 1'b1; ovr_en = 1'b1; ovr_data = 16'hDEAD;
        cyc(1);
        extra_rv = 1'b0; ovr_en = 1'b0; auto_rv = 1'b1;
        chk("flush_req", a_req, 1'b1);
        chk("flush_addr", a_addr, 16'h0100);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flushed", a_pfl, 16'd1);
`endif
        gnt = 1'b1;
        wait_valid("br100");
        chk("br100_instr", a_instr, 16'hA100);
        chk("br100_pc", a_pc, 16'h0100);
        chk("dead_hidden", dead_seen, 1'b0);

        // RESET_PC=FFFF instance wraps to 0000 on its second fetch.
        chk("wrap_g0", grants_b.size() > 1 ? grants_b[0] : 16'hxxxx,
            16'hFFFF);
        chk("wrap_g1", grants_b.size() > 1 ? grants_b[1] : 16'hxxxx,
            16'h0000);

        // Reset while a response is outstanding.
        gnt = 1'b0;
        cyc(1);
        gnt = 1'b1; auto_rv = 1'b0;
        cyc(1);
        rst_n = 1'b0; gnt = 1'b0;
        cyc(1);
        chk("mid_rst_instr", a_instr, 16'h0000);
        chk("mid_rst_pc", a_pc, 16'h0000);
        rst_n = 1'b1; extra_rv = 1'b1;
        cyc(2);
        chk("post_rst_req", a_req, 1'b1);
        chk("post_rst_addr", a_addr, 16'h0000);
        chk("post_rst_valid", a_valid, 1'b0);
        extra_rv = 1'b0; gnt = 1'b1; auto_rv = 1'b1;
        gsz = grants_a.size();
        wait_valid("post_rst");
        chk("post_rst_g", grants_a.size() > gsz ? grants_a[gsz] : 16'hxxxx,
            16'h0000);
        chk("post_rst_instr", a_instr, 16'hA000);
        chk("post_rst_pc", a_pc, 16'h0000);
        cyc(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
